// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the APB general-purpose timer:
//   - byte offsets of the four registers inside the 16-byte window
//   - bit positions of the fields in the CR register
//   - state type of the APB slave handshake FSM
// -----------------------------------------------------------------------------
package timer_pkg;

  // Register offsets (byte addresses, word aligned)
  localparam logic [3:0] ADDR_CR  = 4'h0;
  localparam logic [3:0] ADDR_PSC = 4'h4;
  localparam logic [3:0] ADDR_ARR = 4'h8;
  localparam logic [3:0] ADDR_CNT = 4'hC;

  // CR field positions
  localparam int CR_EN  = 0;  // counter enable
  localparam int CR_CLR = 1;  // write-1 pulse: clear prescaler and counter
  localparam int CR_OPM = 2;  // one-shot mode
  localparam int CR_UIE = 3;  // update interrupt enable
  localparam int CR_UIF = 8;  // sticky update flag, write-1-to-clear

  // APB slave handshake: ACCESS = setup phase seen, READY = PREADY cycle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READY  = 2'd2
  } apb_state_e;

endpackage

// File: rtl/timer_core.sv
// -----------------------------------------------------------------------------
// timer_core
// Prescaler, up-counter with auto-reload compare, one-shot handling and the
// sticky update flag.
//
// Ports
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   psc_i            prescaler value; one tick every psc_i+1 clocks
//   arr_i            reload/compare value; one update every arr_i+1 ticks
//   opm_i            one-shot mode: EN drops on the update
//   cr_wr_i          CR is being written this cycle
//   en_wr_i          EN bit of the CR write data
//   clr_i            CLR pulse (CR write with bit 1 set)
//   uif_clr_i        UIF write-1-to-clear (CR write with bit 8 set)
//   en_o             current EN state
//   cnt_o            counter value
//   uif_o            sticky update flag
//   uev_o            registered one-clock update-event pulse
// -----------------------------------------------------------------------------
module timer_core
  import timer_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int PSC_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic [CNT_WIDTH-1:0] arr_i,
  input  logic                 opm_i,
  input  logic                 cr_wr_i,
  input  logic                 en_wr_i,
  input  logic                 clr_i,
  input  logic                 uif_clr_i,
  output logic                 en_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 uif_o,
  output logic                 uev_o
);

  logic [PSC_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 en_q, en_d;
  logic                 uif_q, uif_d;
  logic                 uev_q, uev_d;
  logic                 tick;
  logic                 update;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    uif_d  = uif_q;

    // >= rather than == so that lowering PSC or ARR below the running
    // count forces the wrap on the next opportunity instead of rolling
    // over the full register width.
    tick   = en_q && (pcnt_q >= psc_i);
    // A CLR write swallows the update of a coincident tick.
    update = tick && (cnt_q >= arr_i) && !clr_i;

    if (clr_i) begin
      pcnt_d = '0;
      cnt_d  = '0;
    end else if (en_q) begin
      pcnt_d = tick ? '0 : pcnt_q + PSC_WIDTH'(1);
      if (tick) begin
        cnt_d = update ? '0 : cnt_q + CNT_WIDTH'(1);
      end
    end

    // A software write of EN takes precedence over the one-shot stop.
    if (cr_wr_i) begin
      en_d = en_wr_i;
    end else if (update && opm_i) begin
      en_d = 1'b0;
    end

    // Hardware set beats software clear so an event is never lost.
    if (update) begin
      uif_d = 1'b1;
    end else if (uif_clr_i) begin
      uif_d = 1'b0;
    end

    uev_d = update;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pcnt_q <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      uif_q  <= 1'b0;
      uev_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      uif_q  <= uif_d;
      uev_q  <= uev_d;
    end
  end

  assign en_o  = en_q;
  assign cnt_o = cnt_q;
  assign uif_o = uif_q;
  assign uev_o = uev_q;

endmodule

// File: rtl/apb_timer_periph.sv
// -----------------------------------------------------------------------------
// apb_timer_periph
// APB slave wrapper around timer_core: one-wait-state handshake, register
// file (CR, PSC, ARR, read-only CNT) and registered readback.
//
// Ports
//   PCLK      clock
//   PRESET    asynchronous active-low reset
//   PADDR     byte address, [1:0] ignored
//   PWDATA    write data
//   PWRITE    1 = write, 0 = read
//   PENABLE   APB access phase
//   PSEL      slave select
//   PRDATA    read data, zero outside the PREADY cycle
//   PREADY    high for exactly one cycle per transfer
//   irq       UIF & UIE
//   uev       one-clock update-event pulse
// -----------------------------------------------------------------------------
module apb_timer_periph
  import timer_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int PSC_WIDTH = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq,
  output logic        uev
);

  apb_state_e           state_q, state_d;
  logic                 access_done;
  logic                 wr_en;
  logic                 cr_wr;
  logic [3:0]           reg_addr;
  logic [31:0]          rdata;
  logic [31:0]          prdata_q;
  logic [PSC_WIDTH-1:0] psc_q;
  logic [CNT_WIDTH-1:0] arr_q;
  logic                 opm_q;
  logic                 uie_q;
  logic                 en;
  logic                 uif;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 unused_bits;

  assign reg_addr    = {PADDR[3:2], 2'b00};
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  // ---------------------------------------------------------------------------
  // APB handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (PSEL && PENABLE) begin
          state_d = READY;
        end else if (PSEL) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (PSEL && PENABLE) begin
          state_d = READY;
        end else if (!PSEL) begin
          state_d = IDLE;
        end
      end
      READY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PREADY = (state_q == READY);
    // The edge that raises PREADY is the edge that commits the transfer;
    // the master still holds PSEL/PENABLE during READY, hence the guard.
    access_done = (state_q != READY) && PSEL && PENABLE;
  end

  assign wr_en = access_done && PWRITE;
  assign cr_wr = wr_en && (reg_addr == ADDR_CR);

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      psc_q <= '0;
      arr_q <= '0;
      opm_q <= 1'b0;
      uie_q <= 1'b0;
    end else if (wr_en) begin
      unique case (reg_addr)
        ADDR_CR: begin
          opm_q <= PWDATA[CR_OPM];
          uie_q <= PWDATA[CR_UIE];
        end
        ADDR_PSC: psc_q <= PWDATA[PSC_WIDTH-1:0];
        ADDR_ARR: arr_q <= PWDATA[CNT_WIDTH-1:0];
        default: ;  // CNT is read-only
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Readback: captured on the commit edge, zero in every other cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    unique case (reg_addr)
      ADDR_CR: begin
        rdata[CR_EN]  = en;
        rdata[CR_OPM] = opm_q;
        rdata[CR_UIE] = uie_q;
        rdata[CR_UIF] = uif;
      end
      ADDR_PSC: rdata = 32'(psc_q);
      ADDR_ARR: rdata = 32'(arr_q);
      ADDR_CNT: rdata = 32'(cnt);
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      prdata_q <= '0;
    end else begin
      prdata_q <= (access_done && !PWRITE) ? rdata : '0;
    end
  end

  assign PRDATA = prdata_q;
  assign irq    = uif & uie_q;

  // ---------------------------------------------------------------------------
  // Timer datapath
  // ---------------------------------------------------------------------------
  timer_core #(
    .CNT_WIDTH (CNT_WIDTH),
    .PSC_WIDTH (PSC_WIDTH)
  ) u_core (
    .clk_i     (PCLK),
    .rst_n_i   (PRESET),
    .psc_i     (psc_q),
    .arr_i     (arr_q),
    .opm_i     (opm_q),
    .cr_wr_i   (cr_wr),
    .en_wr_i   (PWDATA[CR_EN]),
    .clr_i     (cr_wr && PWDATA[CR_CLR]),
    .uif_clr_i (cr_wr && PWDATA[CR_UIF]),
    .en_o      (en),
    .cnt_o     (cnt),
    .uif_o     (uif),
    .uev_o     (uev)
  );

endmodule

// File: doc/apb_timer_periph.md
Name: apb_timer_periph

Overview:
- APB slave general-purpose timer; sits downstream of APB_Master on a spare PSELx/PRDATAx/PREADYx slot, alongside the RAM, GPO and GPI peripherals.
- Has a prescaler, an up-counter with an auto-reload/compare value, and one-shot or periodic mode.
- Produces a sticky update flag, a maskable interrupt and a one-cycle update-event pulse.
- Software polls the flag or takes the interrupt to schedule firmware events.

Parameters:
- CNT_WIDTH, 32, width of counter (CNT) and reload (ARR) registers (1..32).
- PSC_WIDTH, 16, width of prescaler register (PSC) (1..32).

Ports:
- PCLK  input  1  clock.
- PRESET  input  1  reset, asynchronous, active-low.
- PADDR  input  4  byte address within block; word-aligned, [1:0] ignored.
- PWDATA  input  32  write data.
- PWRITE  input  1  1 = write, 0 = read.
- PENABLE  input  1  APB access phase.
- PSEL  input  1  slave select.
- PRDATA  output  32  read data.
- PREADY  output  1  transfer complete.
- irq  output  1  interrupt, equal to UIF & UIE.
- uev  output  1  one-PCLK update-event pulse.

Behaviour:
- Clocking and reset: one clock, PCLK. Reset is asynchronous and active-low on PRESET.
- Reset values:
  - All registers 0; counters 0.
  - PREADY=0, PRDATA=0, irq=0, uev=0.
- Register map (unlisted bits read 0; writes to them are ignored):
  - 0x0 CR:
    - [0] EN.
    - [1] CLR: write-1 pulse, reads 0.
    - [2] OPM: one-shot mode.
    - [3] UIE: interrupt enable.
    - [8] UIF: sticky flag, write-1-to-clear. Writing 0 to bit 8 leaves UIF unchanged.
  - 0x4 PSC[PSC_WIDTH-1:0]: prescaler; tick period = PSC+1 PCLKs.
  - 0x8 ARR[CNT_WIDTH-1:0]: reload/compare value; count period = ARR+1 ticks.
  - 0xC CNT: read-only. Writes complete normally and have no effect.
- APB handshake (one wait state):
  - Setup cycle: PSEL=1, PENABLE=0.
  - First access cycle: PSEL & PENABLE seen, PREADY registered low.
  - Next cycle: PREADY=1 for exactly one cycle. The write commits, or PRDATA is valid, on that edge.
  - PREADY returns to 0 the following cycle. PRDATA=0 whenever PREADY=0.
  - Back-to-back transfers are supported: a new setup phase may start the cycle after PREADY.
- Prescaler:
  - pcnt increments each PCLK while EN=1.
  - When pcnt >= PSC: tick=1 and pcnt<=0.
  - While EN=0: pcnt and CNT hold.
- Counter, on each tick:
  - If CNT >= ARR: CNT<=0, UIF<=1, uev=1 for that cycle. If OPM=1, EN<=0 in the same cycle.
  - Otherwise CNT<=CNT+1.
  - The >= compare means writing ARR below the current CNT causes an update on the next tick, not a wrap at 2^CNT_WIDTH.
- Boundary cases:
  - PSC=0: tick every PCLK.
  - ARR=0 with PSC=0: uev every PCLK while EN=1.
  - CLR=1 write: pcnt<=0 and CNT<=0. CLR wins over a same-cycle tick; no uev is produced that cycle. EN follows the written bit.
  - UIF set and W1C in the same cycle: set wins, UIF stays 1.
  - PSC/ARR written mid-count: take effect on the next compare; counters are not reset.
  - Reset asserted mid-transfer or mid-count: all state returns to reset values immediately. The APB transfer is abandoned with PREADY=0.
- irq is combinational from the registered UIF and UIE (no extra latency). uev is registered.

Decomposition:
- Package timer_pkg:
  - Register offsets: CR=4'h0, PSC=4'h4, ARR=4'h8, CNT=4'hC.
  - CR bit index constants.
  - APB slave state typedef: IDLE, ACCESS, READY.
- Sub-module timer_core: prescaler, counter, compare logic, UIF set/clear arbitration.
- apb_timer_periph: APB decode, register file and readback mux; instantiates timer_core.

Test Plan:
- Reset values: reset mid-run with EN=1, CNT=5 -> CNT, CR, PRDATA, PREADY, irq, uev all 0; read of 0xC returns 0.
- APB timing: write 0x8=0x0000_0003, read back -> PREADY high exactly one cycle, 2 cycles after setup; PRDATA=0x3 only in the PREADY cycle, 0 otherwise.
- Periodic mode: PSC=1, ARR=3, CR=0x9 -> uev every 8 PCLKs; CNT sequence 0,1,2,3,0; UIF=1 and irq=1 after the first update.
- One-shot mode: PSC=0, ARR=2, CR=0x5 -> single uev 3 cycles after enable; then EN reads 0 and CNT holds at 0.
- UIF handling:
  - Write CR bit 8=1 -> UIF=0 and irq drops.
  - Repeat with the W1C write landing on the uev cycle -> UIF stays 1.
- CLR versus tick: PSC=0, ARR=0x10, CNT=7; write CR=0x3 on a tick cycle -> CNT=0 next cycle, no uev, counting resumes from 0.
